lfsr_prbs: RTL
==============

LFSR_PRBS -- requirements
Module: lfsr_prbs

Interface
REQ-001 SHALL have parameter NUM_BITS, default 9, LFSR width; legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 9'h110, NUM_BITS-wide feedback mask; bit i set means state bit i is tapped.
REQ-003 SHALL have parameter LOSS_THRESH, default 4, count of consecutive checker mismatches that drops lock; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enb  input  1  generator step enable.
REQ-007 SHALL have port i_Seed_DV  input  1  seed load strobe, qualified by enb.
REQ-008 SHALL have port i_Seed_Data  input  NUM_BITS  seed value.
REQ-009 SHALL have port o_LFSR_Data  output  NUM_BITS  generator state.
REQ-010 SHALL have port o_LFSR_Bit  output  1  generator serial bit, equal to o_LFSR_Data[0].
REQ-011 SHALL have port o_LFSR_Valid  output  1  one-cycle pulse, cycle after each generator shift.
REQ-012 SHALL have port o_LFSR_Done  output  1  one-cycle pulse when the state returns to the stored seed.
REQ-013 SHALL have port o_Seed_Err  output  1  one-cycle pulse when an all-ones seed is rejected.
REQ-014 SHALL have port i_Rx_Valid  input  1  checker bit strobe.
REQ-015 SHALL have port i_Rx_Bit  input  1  received serial bit.
REQ-016 SHALL have port i_Cnt_Clr  input  1  synchronous clear of the error counter.
REQ-017 SHALL have port o_Lock  output  1  checker locked.
REQ-018 SHALL have port o_Err_Cnt  output  16  saturating mismatch count.

Function
REQ-019 SHALL compute feedback fb as the XNOR reduction of state bits selected by TAPS.
REQ-020 SHALL shift state to {state[NUM_BITS-2:0], fb} when enb=1 and i_Seed_DV=0; otherwise hold.
REQ-021 SHALL, on enb=1 and i_Seed_DV=1, load i_Seed_Data into both state and an internal seed register.
REQ-022 SHALL, if the loaded seed is all-ones (XNOR lockup state), load all-zeros instead and pulse o_Seed_Err in the next cycle.
REQ-023 SHALL pulse o_LFSR_Done in the cycle after a shift whose result equals the seed register; a seed load SHALL NOT pulse Done.
REQ-024 SHALL, with a maximal-length TAPS, pulse Done every 2^NUM_BITS-1 shifts.
REQ-025 SHALL run checker FSM states HUNT and LOCKED, with a NUM_BITS-wide checker register chk and a fill counter.
REQ-026 SHALL, in HUNT on each i_Rx_Valid, shift i_Rx_Bit into chk[0], increment fill, and enter LOCKED once fill reaches NUM_BITS; no errors are counted in HUNT.
REQ-027 SHALL, in LOCKED on each i_Rx_Valid, predict bit p = XNOR of chk bits selected by TAPS, shift p (not i_Rx_Bit) into chk, and flag a mismatch if i_Rx_Bit != p.
REQ-028 SHALL, on a mismatch, increment o_Err_Cnt (saturating at 16'hFFFF) and a consecutive-miss counter; on a match, clear the miss counter.
REQ-029 SHALL, when the miss counter reaches LOSS_THRESH, enter HUNT with fill=0 and miss counter=0; o_Lock falls in the same edge.
REQ-030 SHALL assert o_Lock exactly while the FSM is in LOCKED.
REQ-031 SHALL give i_Cnt_Clr priority over a same-cycle increment, leaving o_Err_Cnt=0.
REQ-032 SHALL keep generator and checker independent; either may be idle while the other runs.

Reset
REQ-033 SHALL, while reset_n=0, hold state=0, seed register=0, o_LFSR_Valid/Done/Seed_Err=0, FSM=HUNT, chk=0, fill=0, miss=0, o_Err_Cnt=0.
REQ-034 SHALL make mid-operation reset effective immediately (asynchronous); the first step after release SHALL follow REQ-020 from state 0.

Verification
REQ-035 SHALL cover: reset, enb=1 with defaults -> o_LFSR_Data 0x001,0x003,0x007,0x00F,0x01F,0x03E on consecutive cycles.
REQ-036 SHALL cover: seed 0x000, 511 enabled cycles -> exactly one Done pulse, on the 511th shift; none before.
REQ-037 SHALL cover: seed load 0x1FF -> state 0x000, o_Seed_Err pulses once, sequence proceeds as in REQ-035.
REQ-038 SHALL cover: generator bit looped to checker -> o_Lock rises after 9 valid bits, o_Err_Cnt stays 0 for 1000 bits.
REQ-039 SHALL cover: in LOCKED, one flipped bit -> o_Err_Cnt=1, o_Lock stays 1; 4 consecutive flipped bits -> o_Err_Cnt=+4, o_Lock=0, relock after 9 clean bits.
REQ-040 SHALL cover: o_Err_Cnt preset to 16'hFFFF by forced errors, further mismatch -> holds 16'hFFFF; i_Cnt_Clr with mismatch -> 0; reset_n pulse mid-stream -> all REQ-033 values.

Source files
------------

// File: rtl/lfsr_prbs_if.sv
// Signal bundle between lfsr_prbs and its environment: PRBS generator controls and
// outputs plus the receive-side checker stream.
interface lfsr_prbs_if #(
  parameter int NUM_BITS = 9
);
  logic                enb;
  logic                i_Seed_DV;
  logic [NUM_BITS-1:0] i_Seed_Data;
  logic [NUM_BITS-1:0] o_LFSR_Data;
  logic                o_LFSR_Bit;
  logic                o_LFSR_Valid;
  logic                o_LFSR_Done;
  logic                o_Seed_Err;
  logic                i_Rx_Valid;
  logic                i_Rx_Bit;
  logic                i_Cnt_Clr;
  logic                o_Lock;
  logic [15:0]         o_Err_Cnt;

  modport master (
    output enb, i_Seed_DV, i_Seed_Data, i_Rx_Valid, i_Rx_Bit, i_Cnt_Clr,
    input  o_LFSR_Data, o_LFSR_Bit, o_LFSR_Valid, o_LFSR_Done, o_Seed_Err,
           o_Lock, o_Err_Cnt
  );

  modport slave (
    input  enb, i_Seed_DV, i_Seed_Data, i_Rx_Valid, i_Rx_Bit, i_Cnt_Clr,
    output o_LFSR_Data, o_LFSR_Bit, o_LFSR_Valid, o_LFSR_Done, o_Seed_Err,
           o_Lock, o_Err_Cnt
  );
endinterface

// File: rtl/lfsr_prbs.sv
// XNOR-feedback PRBS generator with a self-synchronising checker that locks onto
// a received stream, counts bit errors and drops lock after repeated misses.
module lfsr_prbs #(
  parameter int                  NUM_BITS    = 9,
  parameter logic [NUM_BITS-1:0] TAPS        = 9'h110,
  parameter int                  LOSS_THRESH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  lfsr_prbs_if.slave bus
);

  localparam int FILL_W = $clog2(NUM_BITS + 1);

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  logic [NUM_BITS-1:0] state;
  logic [NUM_BITS-1:0] seed_reg;
  logic [NUM_BITS-1:0] shifted;
  logic [NUM_BITS-1:0] load_value;
  logic                fb;
  logic                load;
  logic                step;
  logic                seed_all_ones;
  logic                valid_q;
  logic                done_q;
  logic                seed_err_q;

  chk_state_t          cur_state;
  chk_state_t          nxt_state;
  logic [NUM_BITS-1:0] chk;
  logic [FILL_W-1:0]   fill;
  logic [3:0]          miss;
  logic [15:0]         err_cnt;
  logic                pred;
  logic                mismatch;
  logic                fill_done;
  logic                miss_limit;
  logic                lock;

  assign fb            = ~^(state & TAPS);
  assign shifted       = {state[NUM_BITS-2:0], fb};
  assign load          = bus.enb & bus.i_Seed_DV;
  assign step          = bus.enb & ~bus.i_Seed_DV;
  assign seed_all_ones = &bus.i_Seed_Data;
  // All-ones is the XNOR lockup state, so it is swapped for all-zeros on load.
  assign load_value    = seed_all_ones ? '0 : bus.i_Seed_Data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= '0;
      seed_reg   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      valid_q    <= step;
      done_q     <= step && (shifted == seed_reg);
      seed_err_q <= load && seed_all_ones;
      if (load) begin
        state    <= load_value;
        seed_reg <= load_value;
      end else if (step) begin
        state <= shifted;
      end
    end
  end

  assign pred       = ~^(chk & TAPS);
  assign mismatch   = (cur_state == LOCKED) && bus.i_Rx_Valid && (bus.i_Rx_Bit != pred);
  assign fill_done  = (fill + FILL_W'(1)) == FILL_W'(NUM_BITS);
  assign miss_limit = (miss + 4'd1) == 4'(LOSS_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= HUNT;
    else          cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (bus.i_Rx_Valid) begin
      case (cur_state)
        HUNT:   if (fill_done) nxt_state = LOCKED;
        LOCKED: if (mismatch && miss_limit) nxt_state = HUNT;
      endcase
    end
  end

  always_comb begin
    lock = (cur_state == LOCKED);
  end

  // Once locked, the checker free-runs on its own predictions so a single bad
  // bit is counted once instead of corrupting the following predictions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk     <= '0;
      fill    <= '0;
      miss    <= '0;
      err_cnt <= '0;
    end else begin
      if (bus.i_Rx_Valid) begin
        if (cur_state == HUNT) begin
          chk  <= {chk[NUM_BITS-2:0], bus.i_Rx_Bit};
          fill <= fill + FILL_W'(1);
        end else begin
          chk <= {chk[NUM_BITS-2:0], pred};
          if (mismatch) begin
            if (miss_limit) begin
              miss <= '0;
              fill <= '0;
            end else begin
              miss <= miss + 4'd1;
            end
          end else begin
            miss <= '0;
          end
        end
      end
      if (bus.i_Cnt_Clr)                          err_cnt <= '0;
      else if (mismatch && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.o_LFSR_Data  = state;
  assign bus.o_LFSR_Bit   = state[0];
  assign bus.o_LFSR_Valid = valid_q;
  assign bus.o_LFSR_Done  = done_q;
  assign bus.o_Seed_Err   = seed_err_q;
  assign bus.o_Lock       = lock;
  assign bus.o_Err_Cnt    = err_cnt;

endmodule
